// File: rtl/bank_mem_pkg.sv
// Shared definitions for the 8-bank frame memory: geometry, widths and the
// fill-writer state encoding. Used by the writer, the filter and the bank
// memory wrapper so all three agree on the layout.
package bank_mem_pkg;

  localparam int DATA_W    = 8;     // width of one stored sample
  localparam int NUM_BANKS = 8;     // number of banks, power of two
  localparam int DEPTH     = 8772;  // entries per bank
  localparam int ADDR_W    = 14;    // 2**ADDR_W >= DEPTH
  localparam int CNT_W     = 17;    // 2**CNT_W > NUM_BANKS*DEPTH

  localparam int SEL_W         = $clog2(NUM_BANKS);
  localparam int FRAME_SAMPLES = NUM_BANKS * DEPTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  // One-hot decode of a bank index into a per-bank strobe vector.
  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_BANKS-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bank_addr_gen.sv
// Round-robin bank/address sequencer for the frame fill. bank_sel walks
// 0..NUM_BANKS-1, addr steps each time bank_sel wraps, and count tracks the
// total number of samples placed in the current frame.
module bank_addr_gen
  import bank_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [SEL_W-1:0]  bank_sel_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              last_o
);

  logic [SEL_W-1:0]  bank_sel_q, bank_sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sel_wrap;
  logic              addr_last;

  assign sel_wrap  = (bank_sel_q == SEL_W'(NUM_BANKS - 1));
  assign addr_last = (addr_q == ADDR_W'(DEPTH - 1));

  // Next position: clear wins (frame start), otherwise step on each accept.
  // addr stops at DEPTH-1 so it never points past the end of a bank.
  always_comb begin
    bank_sel_d = bank_sel_q;
    addr_d     = addr_q;
    count_d    = count_q;
    if (clear_i) begin
      bank_sel_d = '0;
      addr_d     = '0;
      count_d    = '0;
    end else if (advance_i) begin
      count_d = count_q + CNT_W'(1);
      if (sel_wrap) begin
        bank_sel_d = '0;
        if (!addr_last) begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end else begin
        bank_sel_d = bank_sel_q + SEL_W'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel_q <= '0;
      addr_q     <= '0;
      count_q    <= '0;
    end else begin
      bank_sel_q <= bank_sel_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
    end
  end

  assign bank_sel_o = bank_sel_q;
  assign addr_o     = addr_q;
  assign count_o    = count_q;
  assign last_o     = sel_wrap & addr_last;

endmodule

// File: rtl/bank_fill_writer.sv
// Writer side of the 8-bank frame memory. Takes a serial byte stream and
// spreads it round-robin over the banks (byte k -> bank k mod 8, address
// k div 8), producing per-bank strobes with shared address and data, and
// flags completion so the filter can start reading.
//
// Handshake: a sample is transferred on every rising clk edge where
// in_valid and in_ready are both high. in_ready is high exactly while the
// FSM is in FILL and does not depend on in_valid; the source must hold
// in_data stable while in_valid is high and not yet accepted.
module bank_fill_writer
  import bank_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic [NUM_BANKS-1:0] wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     count,
  output logic [1:0]           dbg_state
);

  state_e state_q, state_d;

  logic              accept;
  logic              clear;
  logic              last;
  logic [SEL_W-1:0]  bank_sel;
  logic [ADDR_W-1:0] addr;

  logic [NUM_BANKS-1:0] wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;

  bank_addr_gen u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear),
    .advance_i  (accept),
    .bank_sel_o (bank_sel),
    .addr_o     (addr),
    .count_o    (count),
    .last_o     (last)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start only matters outside FILL; the final accept
  // (last bank, last address) ends the frame on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (accept && last) state_d = DONE;
      DONE:    if (start) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshake, status flags and the counter clear on frame entry.
  always_comb begin
    in_ready = (state_q == FILL);
    busy     = (state_q == FILL);
    done     = (state_q == DONE);
    accept   = in_valid & (state_q == FILL);
    clear    = start & (state_q != FILL);
  end

  // Write port next values: strobe only on an accept, address/data hold
  // their last values otherwise.
  always_comb begin
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (accept) begin
      wr_en_d   = bank_onehot(bank_sel);
      wr_addr_d = addr;
      wr_data_d = in_data;
    end
  end

  // Write port registers: one cycle from accept to strobe. Reset drops any
  // strobe that would have been registered on the reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bank_fill_writer.sv
// Bench for bank_fill_writer: scenario tasks drive the byte stream, a
// scoreboard holds the expected strobe for every accepted byte, and a
// monitor checks strobes one cycle after their accept and fills a bank model.
module tb_bank_fill_writer;
  import bank_mem_pkg::*;

  localparam int W = NUM_BANKS + ADDR_W + DATA_W;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 in_valid;
  logic [DATA_W-1:0]    in_data;
  logic                 in_ready;
  logic [NUM_BANKS-1:0] wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     count;
  logic [1:0]           dbg_state;

  always #5 clk = ~clk;

  bank_fill_writer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  int           due_q[$];

  // Reference sequencer: next bank, address and byte index in the frame.
  int m_bank  = 0;
  int m_addr  = 0;
  int m_count = 0;

  logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    got = {wr_en, wr_addr, wr_data};
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      exp = exp_q.pop_front();
      void'(due_q.pop_front());
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL sb_strobe cyc=%0d got en=%h addr=%0d data=%h exp en=%h addr=%0d data=%h",
                 cyc, got[W-1 -: NUM_BANKS], got[DATA_W +: ADDR_W], got[DATA_W-1:0],
                 exp[W-1 -: NUM_BANKS], exp[DATA_W +: ADDR_W], exp[DATA_W-1:0]);
      end
    end else begin
      total++;
      if (wr_en !== '0) begin
        bad++;
        $display("FAIL sb_spurious cyc=%0d got wr_en=%h exp wr_en=00", cyc, wr_en);
      end
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_en[b] === 1'b1 && wr_addr < ADDR_W'(DEPTH)) mem[b][wr_addr] = wr_data;
    end
  end

  // ---------------- driver tasks ----------------
  // Present one byte and hold it until accepted; the expected strobe is
  // queued for the cycle after the accepting edge. Returns at #1 past that edge.
  task automatic send_byte(input logic [DATA_W-1:0] d, output bit ok);
    logic [NUM_BANKS-1:0] oh;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        oh = NUM_BANKS'(1) << m_bank;
        exp_q.push_back({oh, ADDR_W'(m_addr), d});
        due_q.push_back(cyc + 1);
        m_count++;
        m_bank++;
        if (m_bank == NUM_BANKS) begin
          m_bank = 0;
          m_addr++;
        end
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout got in_ready=%b exp in_ready=1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_next(output bit ok);
    send_byte(DATA_W'(m_count % 256), ok);
  endtask

  // Pulse start for one cycle; the reference resets only where start is honoured.
  task automatic do_start(input bit clears);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (clears) begin
      m_bank  = 0;
      m_addr  = 0;
      m_count = 0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({in_ready, wr_en, done, count} !== '0) begin
        bad++;
        $display("FAIL reset_outputs got rdy=%b en=%h done=%b cnt=%0d exp all 0", in_ready, wr_en, done, count);
      end
      total++;
      if (dbg_state !== IDLE) begin
        bad++;
        $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({in_ready, wr_en, done, busy, count} !== '0) begin
        bad++;
        $display("FAIL idle_valid got rdy=%b en=%h done=%b busy=%b cnt=%0d exp all 0",
                 in_ready, wr_en, done, busy, count);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_first_samples();
    bit ok;
    do_start(1'b1);
    @(negedge clk);
    total++;
    if ({busy, in_ready, done, count} !== {1'b1, 1'b1, 1'b0, CNT_W'(0)}) begin
      bad++;
      $display("FAIL fill_entry got busy=%b rdy=%b done=%b cnt=%0d exp 1 1 0 0", busy, in_ready, done, count);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) send_next(ok);
    @(negedge clk);
    total++;
    if ({wr_en, wr_addr, wr_data} !== {8'h01, 14'd1, 8'h08}) begin
      bad++;
      $display("FAIL ninth_byte got en=%h addr=%0d data=%h exp en=01 addr=1 data=08", wr_en, wr_addr, wr_data);
    end
    total++;
    if (count !== CNT_W'(9)) begin
      bad++;
      $display("FAIL count_9 got %0d exp 9", count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_gapped();
    bit ok;
    send_next(ok);
    @(negedge clk);
    total++;
    if ({wr_en, wr_addr} !== {8'h02, 14'd1}) begin
      bad++;
      $display("FAIL gap_first got en=%h addr=%0d exp en=02 addr=1", wr_en, wr_addr);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if ({wr_en, count, busy} !== {8'h00, CNT_W'(10), 1'b1}) begin
      bad++;
      $display("FAIL gap_hold got en=%h cnt=%0d busy=%b exp en=00 cnt=10 busy=1", wr_en, count, busy);
    end
    @(posedge clk);
    #1;
    send_next(ok);
    @(negedge clk);
    total++;
    if ({wr_en, wr_addr, wr_data} !== {8'h04, 14'd1, 8'h0A}) begin
      bad++;
      $display("FAIL gap_second got en=%h addr=%0d data=%h exp en=04 addr=1 data=0a", wr_en, wr_addr, wr_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_start_ignored();
    do_start(1'b0);
    @(negedge clk);
    total++;
    if ({busy, in_ready, count} !== {1'b1, 1'b1, CNT_W'(m_count)}) begin
      bad++;
      $display("FAIL start_in_fill got busy=%b rdy=%b cnt=%0d exp 1 1 %0d", busy, in_ready, count, m_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_frame();
    bit ok;
    int errs;
    ok = 1'b1;
    while (m_count < FRAME_SAMPLES && ok) send_next(ok);
    @(negedge clk);
    total++;
    if ({wr_en, wr_addr, wr_data} !== {8'h80, 14'd8771, 8'h1F}) begin
      bad++;
      $display("FAIL last_strobe got en=%h addr=%0d data=%h exp en=80 addr=8771 data=1f", wr_en, wr_addr, wr_data);
    end
    total++;
    if ({done, busy, in_ready, count} !== {1'b1, 1'b0, 1'b0, CNT_W'(70176)}) begin
      bad++;
      $display("FAIL frame_done got done=%b busy=%b rdy=%b cnt=%0d exp 1 0 0 70176", done, busy, in_ready, count);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({in_ready, wr_en, done, count} !== {1'b0, 8'h00, 1'b1, CNT_W'(70176)}) begin
        bad++;
        $display("FAIL done_hold got rdy=%b en=%h done=%b cnt=%0d exp 0 00 1 70176", in_ready, wr_en, done, count);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      errs = 0;
      for (int a = 0; a < DEPTH; a++) begin
        if (mem[b][a] !== DATA_W'((8 * a + b) % 256)) errs++;
      end
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL bank_layout bank=%0d got %0d wrong entries exp 0", b, errs);
      end
    end
  endtask

  task automatic test_restart_from_done();
    bit ok;
    do_start(1'b1);
    @(negedge clk);
    total++;
    if ({done, busy, in_ready, count} !== {1'b0, 1'b1, 1'b1, CNT_W'(0)}) begin
      bad++;
      $display("FAIL restart got done=%b busy=%b rdy=%b cnt=%0d exp 0 1 1 0", done, busy, in_ready, count);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_next(ok);
  endtask

  task automatic test_abort();
    bit ok;
    ok = 1'b1;
    while (m_count < 100 && ok) send_next(ok);
    in_valid = 1'b1;
    in_data  = 8'h55;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({wr_en, count, busy, done, in_ready} !== '0) begin
      bad++;
      $display("FAIL abort got en=%h cnt=%0d busy=%b done=%b rdy=%b exp all 0", wr_en, count, busy, done, in_ready);
    end
    total++;
    if (dbg_state !== IDLE) begin
      bad++;
      $display("FAIL abort_state got %0d exp %0d", dbg_state, IDLE);
    end
    @(posedge clk);
    #1;
    do_start(1'b1);
    send_next(ok);
    @(negedge clk);
    total++;
    if ({wr_en, wr_addr, wr_data} !== {8'h01, 14'd0, 8'h00}) begin
      bad++;
      $display("FAIL refill got en=%h addr=%0d data=%h exp en=01 addr=0 data=00", wr_en, wr_addr, wr_data);
    end
    @(posedge clk);
    #1;
    send_next(ok);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_first_samples();
    test_gapped();
    test_start_ignored();
    test_full_frame();
    test_restart_from_done();
    test_abort();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got %0d pending exp 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
